// File: rtl/trackball_pkg.sv
// Shared types and helpers for the trackball CLK/DIR pulse generator.
// Quadrature helper is used only when TRACKBALL_QUAD_AB_EN is defined.
package trackball_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW
    } axis_state_t;

    localparam int unsigned PEND_W_DEF = 10;
    localparam int unsigned DELTA_W    = 8;

    // One Gray-code step: 00->01->11->10 when up, reverse otherwise.
    function automatic logic [1:0] gray_step(input logic [1:0] i_gray, input logic i_up);
        logic [1:0] w_bin;
        w_bin = {i_gray[1], i_gray[1] ^ i_gray[0]};
        w_bin = i_up ? w_bin + 2'd1 : w_bin - 2'd1;
        return {w_bin[1], w_bin[1] ^ w_bin[0]};
    endfunction

endpackage

// File: rtl/trackball_axis_gen.sv
// One axis: signed pending-step accumulator feeding an IDLE/SETUP/HIGH/LOW pulse FSM.
// Build option TRACKBALL_QUAD_AB_EN adds a per-axis quadrature Gray counter.
module trackball_axis_gen
    import trackball_pkg::*;
#(
    parameter int unsigned SETUP_CYC = 8,
    parameter int unsigned HIGH_CYC  = 57,
    parameter int unsigned LOW_CYC   = 57,
    parameter int unsigned PEND_W    = PEND_W_DEF
) (
    input  logic                      GCLK,
    input  logic                      reset_n,
    input  logic                      i_add_en,
    input  logic signed [DELTA_W-1:0] i_delta,
    output logic signed [PEND_W-1:0]  o_pending,
    output logic                      o_clk,
    output logic                      o_dir,
    output logic                      o_busy
`ifdef TRACKBALL_QUAD_AB_EN
    ,
    output logic                      o_quad_a,
    output logic                      o_quad_b
`endif
);

    localparam int unsigned MAX_HL  = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
    localparam int unsigned MAX_CYC = (SETUP_CYC > MAX_HL) ? SETUP_CYC : MAX_HL;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] HIGH_LD  = CNT_W'(HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] LOW_LD   = CNT_W'(LOW_CYC - 1);

    axis_state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
    logic signed [PEND_W-1:0] r_pending, w_pending_nxt;
    logic                     r_clk, r_dir, r_busy;
    logic                     w_dir_nxt, w_enter_high, w_clk_nxt, w_busy_nxt;
    logic                     w_nz, w_pos, w_cnt_done;

    assign w_nz       = (r_pending != '0);
    assign w_pos      = w_nz && !r_pending[PEND_W-1];
    assign w_cnt_done = (r_cnt == '0);

    always_ff @(posedge GCLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pending <= '0;
            r_clk     <= 1'b0;
            r_dir     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pending_nxt;
            r_clk     <= w_clk_nxt;
            r_dir     <= w_dir_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // SETUP and LOW share the exit decision, so a delta that cancels or reverses
    // pending during SETUP is re-evaluated before any pulse is issued.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_dir_nxt    = r_dir;
        w_enter_high = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_nz) begin
                    w_state_nxt = SETUP;
                    w_dir_nxt   = w_pos;
                    w_cnt_nxt   = SETUP_LD;
                end
            end
            HIGH: begin
                if (w_cnt_done) begin
                    w_state_nxt = LOW;
                    w_cnt_nxt   = LOW_LD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            SETUP, LOW: begin
                if (!w_cnt_done) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (!w_nz) begin
                    w_state_nxt = IDLE;
                end else if (w_pos == r_dir) begin
                    w_state_nxt  = HIGH;
                    w_cnt_nxt    = HIGH_LD;
                    w_enter_high = 1'b1;
                end else begin
                    w_state_nxt = SETUP;
                    w_dir_nxt   = w_pos;
                    w_cnt_nxt   = SETUP_LD;
                end
            end
        endcase
    end

    always_comb begin
        w_pending_nxt = r_pending;
        if (i_add_en) begin
            w_pending_nxt = w_pending_nxt + PEND_W'(i_delta);
        end
        if (w_enter_high) begin
            w_pending_nxt = r_dir ? w_pending_nxt - PEND_W'(1) : w_pending_nxt + PEND_W'(1);
        end
        w_clk_nxt  = (w_state_nxt == HIGH);
        w_busy_nxt = (w_state_nxt != IDLE) || (w_pending_nxt != '0);
    end

    assign o_pending = r_pending;
    assign o_clk     = r_clk;
    assign o_dir     = r_dir;
    assign o_busy    = r_busy;

`ifdef TRACKBALL_QUAD_AB_EN
    logic [1:0] r_quad;

    always_ff @(posedge GCLK or negedge reset_n) begin
        if (!reset_n) begin
            r_quad <= '0;
        end else if (w_enter_high) begin
            r_quad <= gray_step(r_quad, r_dir);
        end
    end

    assign o_quad_a = r_quad[1];
    assign o_quad_b = r_quad[0];
`endif

endmodule

// File: rtl/trackball_quad_gen.sv
// Trackball-side CLK/DIR transmitter: request decode and in_ready, one axis generator per channel.
// Define TRACKBALL_QUAD_AB_EN to add quad_a/quad_b quadrature outputs.
module trackball_quad_gen
    import trackball_pkg::*;
#(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned SETUP_CYC = 8,
    parameter int unsigned HIGH_CYC  = 57,
    parameter int unsigned LOW_CYC   = 57,
    parameter int unsigned PEND_W    = PEND_W_DEF,
    localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      GCLK,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CH_W-1:0]           in_chan,
    input  logic signed [DELTA_W-1:0] in_delta,
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS-1:0]       dir_out,
    output logic [CHANNELS-1:0]       busy
`ifdef TRACKBALL_QUAD_AB_EN
    ,
    output logic [CHANNELS-1:0]       quad_a,
    output logic [CHANNELS-1:0]       quad_b
`endif
);

    logic signed [PEND_W-1:0] w_pending [CHANNELS];
    logic signed [PEND_W-1:0] w_sel_pending;
    logic signed [PEND_W:0]   w_sum;
    logic                     w_chan_ok;
    logic                     w_fits;
    logic [CHANNELS-1:0]      w_add_en;

    always_comb begin
        w_sel_pending = '0;
        w_chan_ok     = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (in_chan == CH_W'(i)) begin
                w_sel_pending = w_pending[i];
                w_chan_ok     = 1'b1;
            end
        end
    end

    // One guard bit: the sum fits when the top two bits agree.
    assign w_sum    = (PEND_W + 1)'(w_sel_pending) + (PEND_W + 1)'(in_delta);
    assign w_fits   = (w_sum[PEND_W] == w_sum[PEND_W-1]);
    assign in_ready = !w_chan_ok || w_fits;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_axis
        assign w_add_en[g] = in_valid && in_ready && w_chan_ok && (in_chan == CH_W'(g));

        trackball_axis_gen #(
            .SETUP_CYC(SETUP_CYC),
            .HIGH_CYC (HIGH_CYC),
            .LOW_CYC  (LOW_CYC),
            .PEND_W   (PEND_W)
        ) u_axis (
            .GCLK     (GCLK),
            .reset_n  (reset_n),
            .i_add_en (w_add_en[g]),
            .i_delta  (in_delta),
            .o_pending(w_pending[g]),
            .o_clk    (clk_out[g]),
            .o_dir    (dir_out[g]),
            .o_busy   (busy[g])
`ifdef TRACKBALL_QUAD_AB_EN
            ,
            .o_quad_a (quad_a[g]),
            .o_quad_b (quad_b[g])
`endif
        );
    end

endmodule
